// File: rtl/sequentieller_schieber_if.sv
// sequentieller_schieber_if: start/ready and done/acknowledge bundle for the serial shifter
interface sequentieller_schieber_if #(
    parameter int BREITE     = 32,
    parameter int LOG2BREITE = 5
);
    logic                  Start;
    logic [BREITE-1:0]     Zahl;
    logic [LOG2BREITE-1:0] Stellen;
    logic [2:0]            Modus;
    logic                  Bereit;
    logic                  Fertig;
    logic                  Quittung;
    logic [BREITE-1:0]     Ergebnis;
    modport master (output Start, Zahl, Stellen, Modus, Quittung, input Bereit, Fertig, Ergebnis);
    modport slave  (input Start, Zahl, Stellen, Modus, Quittung, output Bereit, Fertig, Ergebnis);
endinterface

// File: rtl/sequentieller_schieber.sv
// sequentieller_schieber: one-bit-per-clock rotate/logical/arithmetic shifter with handshakes
module sequentieller_schieber #(
    parameter int BREITE     = 32,
    parameter int LOG2BREITE = 5
) (
    input logic                    Takt,
    input logic                    nReset,
    sequentieller_schieber_if.slave bus
);
    localparam logic [1:0] LEERLAUF = 2'd0;
    localparam logic [1:0] SCHIEBEN = 2'd1;
    localparam logic [1:0] FERTIG   = 2'd2;
    logic [1:0]            state;
    logic [BREITE-1:0]     wert;
    logic [BREITE-1:0]     schritt;
    logic [LOG2BREITE-1:0] zaehler;
    logic [2:0]            modus;
    // reserved encodings hold the register while the counter keeps running
    always_comb
        schritt = modus == 3'b000 ? {wert[BREITE-2:0], wert[BREITE-1]} :
                  modus == 3'b001 ? {wert[0], wert[BREITE-1:1]} :
                  modus == 3'b010 ? {wert[BREITE-2:0], 1'b0} :
                  modus == 3'b011 ? {1'b0, wert[BREITE-1:1]} :
                  modus == 3'b100 ? {wert[BREITE-1], wert[BREITE-1:1]} : wert;
    assign bus.Bereit   = state == LEERLAUF;
    assign bus.Fertig   = state == FERTIG;
    assign bus.Ergebnis = wert;
    always_ff @(posedge Takt or negedge nReset)
        if (!nReset) begin
            state   <= LEERLAUF;
            wert    <= '0;
            zaehler <= '0;
            modus   <= '0;
        end else
            case (state)
                LEERLAUF: if (bus.Start) begin
                    wert    <= bus.Zahl;
                    zaehler <= bus.Stellen;
                    modus   <= bus.Modus;
                    state   <= bus.Stellen == '0 ? FERTIG : SCHIEBEN;
                end
                SCHIEBEN: begin
                    wert    <= schritt;
                    zaehler <= zaehler - LOG2BREITE'(1);
                    if (zaehler == LOG2BREITE'(1)) state <= FERTIG;
                end
                FERTIG:   if (bus.Quittung) state <= LEERLAUF;
                default:  state <= LEERLAUF;
            endcase
endmodule

// File: tb/tb_sequentieller_schieber.sv
// tb_sequentieller_schieber: table-driven vectors plus handshake and reset corner sequences
module tb_sequentieller_schieber;
    logic Takt = 1'b0;
    logic nReset = 1'b0;
    int   n_checks = 0;
    int   n_fails = 0;
    sequentieller_schieber_if #(.BREITE(32), .LOG2BREITE(5)) bus ();
    sequentieller_schieber #(.BREITE(32), .LOG2BREITE(5)) dut (.Takt(Takt), .nReset(nReset), .bus(bus));
    always #5 Takt = ~Takt;

    typedef struct {
        logic [2:0]  modus;
        logic [31:0] zahl;
        logic [4:0]  stellen;
        logic [31:0] erwartet;
    } vektor_t;
    vektor_t tabelle [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Takt);
        #1;
    endtask

    task automatic launch(input logic [2:0] m, input logic [31:0] z, input logic [4:0] s);
        bus.Modus = m;
        bus.Zahl = z;
        bus.Stellen = s;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic wait_fertig(output int edges);
        edges = 0;
        while (!bus.Fertig && edges < 100) begin
            tick();
            edges++;
        end
    endtask

    task automatic acknowledge(input string name);
        bus.Quittung = 1'b1;
        tick();
        bus.Quittung = 1'b0;
        check({name, " bereit after ack"}, {31'b0, bus.Bereit}, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [2:0] m, input logic [31:0] z,
                          input logic [4:0] s, input logic [31:0] exp);
        int e;
        launch(m, z, s);
        wait_fertig(e);
        check({name, " latency"}, e, {27'b0, s});
        check({name, " ergebnis"}, bus.Ergebnis, exp);
        acknowledge(name);
    endtask

    initial begin
        int e;
        logic [31:0] r;
        tabelle[0]  = '{3'b000, 32'h80000001, 5'd4,  32'h00000018};
        tabelle[1]  = '{3'b001, 32'h00000003, 5'd1,  32'h80000001};
        tabelle[2]  = '{3'b100, 32'h80000000, 5'd31, 32'hFFFFFFFF};
        tabelle[3]  = '{3'b011, 32'h12345678, 5'd0,  32'h12345678};
        tabelle[4]  = '{3'b010, 32'hFFFFFFFF, 5'd8,  32'hFFFFFF00};
        tabelle[5]  = '{3'b011, 32'hFFFFFFFF, 5'd8,  32'h00FFFFFF};
        tabelle[6]  = '{3'b110, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF};
        tabelle[7]  = '{3'b100, 32'h40000000, 5'd31, 32'h00000000};
        tabelle[8]  = '{3'b000, 32'h00000001, 5'd31, 32'h80000000};
        tabelle[9]  = '{3'b001, 32'h12345678, 5'd4,  32'h81234567};
        tabelle[10] = '{3'b111, 32'hA5A5A5A5, 5'd3,  32'hA5A5A5A5};
        tabelle[11] = '{3'b101, 32'h0F0F0F0F, 5'd31, 32'h0F0F0F0F};
        tabelle[12] = '{3'b100, 32'h80000010, 5'd4,  32'hF8000001};
        tabelle[13] = '{3'b010, 32'h00000001, 5'd31, 32'h80000000};
        bus.Start = 1'b0;
        bus.Quittung = 1'b0;
        bus.Zahl = '0;
        bus.Stellen = '0;
        bus.Modus = '0;
        #23;
        check("reset bereit", {31'b0, bus.Bereit}, 32'd1);
        check("reset fertig", {31'b0, bus.Fertig}, 32'd0);
        check("reset ergebnis", bus.Ergebnis, 32'h0);
        nReset = 1'b1;
        tick();

        foreach (tabelle[i])
            run_op($sformatf("vec%0d", i), tabelle[i].modus, tabelle[i].zahl,
                   tabelle[i].stellen, tabelle[i].erwartet);

        // asynchronous reset in the middle of a long shift
        launch(3'b000, 32'h80000001, 5'd20);
        repeat (4) tick();
        #2;
        nReset = 1'b0;
        #1;
        check("midreset bereit", {31'b0, bus.Bereit}, 32'd1);
        check("midreset fertig", {31'b0, bus.Fertig}, 32'd0);
        check("midreset ergebnis", bus.Ergebnis, 32'h0);
        #4;
        nReset = 1'b1;
        tick();
        run_op("after reset", 3'b011, 32'h80000000, 5'd3, 32'h10000000);

        // result stays stable while unacknowledged
        launch(3'b000, 32'h80000001, 5'd4);
        wait_fertig(e);
        check("hold latency", e, 32'd4);
        for (int k = 0; k < 10; k++) begin
            bus.Quittung = 1'b0;
            tick();
            check($sformatf("hold%0d fertig", k), {31'b0, bus.Fertig}, 32'd1);
            check($sformatf("hold%0d ergebnis", k), bus.Ergebnis, 32'h00000018);
        end
        acknowledge("hold");

        // start pulses, stray Quittung and operand changes mid-shift
        launch(3'b011, 32'hF0000000, 5'd8);
        tick();
        bus.Start = 1'b1;
        bus.Quittung = 1'b1;
        bus.Zahl = 32'h12345678;
        bus.Stellen = 5'd1;
        bus.Modus = 3'b000;
        tick();
        bus.Start = 1'b0;
        bus.Quittung = 1'b0;
        check("abuse busy", {31'b0, bus.Bereit}, 32'd0);
        wait_fertig(e);
        check("abuse latency", e + 2, 32'd8);
        check("abuse ergebnis", bus.Ergebnis, 32'h00F00000);

        // Start held through the acknowledge edge: no accept there, accept one cycle later
        bus.Zahl = 32'h00000001;
        bus.Stellen = 5'd2;
        bus.Modus = 3'b001;
        bus.Start = 1'b1;
        bus.Quittung = 1'b1;
        tick();
        bus.Quittung = 1'b0;
        check("ack+start bereit", {31'b0, bus.Bereit}, 32'd1);
        check("ack+start ergebnis", bus.Ergebnis, 32'h00F00000);
        tick();
        bus.Start = 1'b0;
        check("backtoback accepted", {31'b0, bus.Bereit}, 32'd0);
        wait_fertig(e);
        r = 32'h40000000;
        check("backtoback latency", e, 32'd2);
        check("backtoback ergebnis", bus.Ergebnis, r);
        acknowledge("backtoback");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
